// File: rtl/hack_pkg.sv
// Shared definitions for the clearable word RAM.
//   WORD_W      - default data word width
//   ram_state_t - clear controller state (IDLE / CLEAR)
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/word_reg.sv
// One data word of the RAM: a plain load-enabled register with no reset.
// Ports:
//   clk   - clock, rising edge
//   load  - capture d_in on the next rising edge
//   d_in  - data to store
//   d_out - stored data
module word_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  always_ff @(posedge clk) begin
    if (load) begin
      d_out <= d_in;
    end
  end

endmodule

// File: rtl/ram8_clear.sv
// Small word RAM that wipes itself to zero after every reset.
// After rst drops, one word per clock is cleared (DEPTH cycles in total);
// busy is high for that time, user writes are ignored and d_out reads 0.
// Ports:
//   clk     - single clock, rising edge
//   rst     - synchronous active-high reset, restarts the clear sequence
//   load    - write enable for the word at address
//   address - word select for both read and write
//   d_in    - write data
//   d_out   - combinational read data for address (0 while busy)
//   busy    - clear sequence in progress
// Build option:
//   RAM8_READ_BYPASS_EN - when defined, a write in IDLE is forwarded from
//                         d_in to d_out in the same cycle.
//
// state | meaning
// IDLE  | normal read/write operation
// CLEAR | writing 0 to mem[ptr], one word per clock
module ram8_clear
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  output logic              busy
);

  ram_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic              clearing;
  logic              bypass_hit;
  logic [WIDTH-1:0]  word_q [DEPTH];

  assign clearing = (state == CLEAR);
  assign busy     = clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == ADDR_W'(DEPTH - 1)) begin
        state <= IDLE;
      end
    end
  end

  // Clearing reuses each word's normal load path with zero data, so the
  // word registers themselves need no reset. rst blocks every write.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    assign wr_en   = !rst && (clearing ? (ptr == ADDR_W'(gi))
                                       : (load && address == ADDR_W'(gi)));
    assign wr_data = clearing ? '0 : d_in;

    word_reg #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .load  (wr_en),
      .d_in  (wr_data),
      .d_out (word_q[gi])
    );
  end

`ifdef RAM8_READ_BYPASS_EN
  assign bypass_hit = load;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    d_out = '0;
    if (!busy) begin
      d_out = bypass_hit ? d_in : word_q[address];
    end
  end

endmodule

// File: tb/tb_ram8_clear.sv
module tb_ram8_clear;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [2:0]   address;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RAM8_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ram8_clear dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .address (address),
    .d_in    (d_in),
    .d_out   (d_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a reset arms a countdown of D clear cycles; when it
  // expires the whole memory is zero. Otherwise loads store d_in.
  logic [W-1:0] m_mem [D];
  int           m_remaining = 0;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_remaining = D;
      m_valid     = 1'b1;
    end else if (m_remaining > 0) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        for (int i = 0; i < D; i++) m_mem[i] = '0;
      end
    end else if (load) begin
      m_mem[address] = d_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic         exp_busy;
    logic [W-1:0] exp_dout;
    if (m_valid) begin
      exp_busy = (m_remaining > 0);
      if (exp_busy)            exp_dout = '0;
      else if (BYPASS && load) exp_dout = d_in;
      else                     exp_dout = m_mem[address];
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, exp_busy);
      end
      n_checks++;
      if (d_out !== exp_dout) begin
        n_fail++;
        $display("FAIL model_dout t=%0t addr=%0d got=%h exp=%h", $time, address, d_out, exp_dout);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic read_check(input string name, input int a, input logic [W-1:0] exp);
    address = 3'(a);
    #1;
    check_lit(name, d_out, exp);
  endtask

  // Counts samples with busy high, starting at the current point.
  task automatic count_busy(input string name, input int exp_cycles);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    check_lit(name, W'(cnt), W'(exp_cycles));
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy !== 1'b0 && cnt < 40) begin
      cnt++;
      step();
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle got=%b exp=0", busy);
    end
  endtask

  task automatic write_word(input int a, input logic [W-1:0] v);
    load = 1'b1; address = 3'(a); d_in = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; address = '0; d_in = '0;

    // Reset clear
    step();
    check_lit("rst_busy", W'(busy), 16'h1);
    check_lit("rst_dout", d_out, 16'h0);
    rst = 1'b0;
    count_busy("clear_len", 8);
    for (int i = 0; i < D; i++) read_check("clear_zero", i, 16'h0000);

    // Basic write
    write_word(3, 16'hBEEF);
    read_check("write_a3", 3, 16'hBEEF);
    read_check("write_a2", 2, 16'h0000);
    read_check("write_a4", 4, 16'h0000);

    // Write while busy (cycles 2-4 of a clear)
    rst = 1'b1; step(); rst = 1'b0;
    step();
    load = 1'b1; address = 3'd5; d_in = 16'h1234;
    step(); step(); step();
    load = 1'b0;
    wait_idle();
    read_check("busy_write_ignored", 5, 16'h0000);

    // Reset mid-clear
    write_word(1, 16'h5A5A);
    read_check("pre_mid_a1", 1, 16'h5A5A);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    count_busy("mid_clear_len", 8);
    for (int i = 0; i < D; i++) read_check("mid_clear_zero", i, 16'h0000);

    // Back-to-back writes
    load = 1'b1; address = 3'd7; d_in = 16'h0001;
    step();
    d_in = 16'hFFFF;
    #1;
    if (BYPASS) check_lit("bypass_same_cycle", d_out, 16'hFFFF);
    else        check_lit("no_bypass_old_value", d_out, 16'h0001);
    step();
    load = 1'b0;
    read_check("b2b_last_wins", 7, 16'hFFFF);

    // Write then reset with load held
    write_word(0, 16'hAAAA);
    read_check("pre_rst_a0", 0, 16'hAAAA);
    rst = 1'b1; load = 1'b1; address = 3'd0; d_in = 16'h5555;
    step();
    rst = 1'b0; load = 1'b0;
    check_lit("rst_load_busy", W'(busy), 16'h1);
    wait_idle();
    read_check("rst_load_a0", 0, 16'h0000);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      load    = $urandom_range(0, 1);
      address = 3'($urandom_range(0, D - 1));
      d_in    = W'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram8_clear.md
RAM8_CLEAR -- requirements
Module: ram8_clear

Interface
REQ-001 Parameter: WIDTH, default 16, data word width in bits.
REQ-002 Parameter: DEPTH, default 8, number of words; a power of two, at least 2.
REQ-003 Derived constant: ADDR_W = log2(DEPTH), which is 3 at default.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Port: load  input  1  write enable for the word at address.
REQ-007 Port: address  input  ADDR_W  word select, used for both read and write.
REQ-008 Port: d_in  input  WIDTH  write data.
REQ-009 Port: d_out  output  WIDTH  read data for address.
REQ-010 Port: busy  output  1  high while the clear sequence runs.

Function
REQ-011 The block SHALL have two states: IDLE and CLEAR.
REQ-012 Clear sequence:
- In CLEAR with rst low, each rising edge SHALL write 0 to mem[ptr] and then increment ptr.
- The edge that clears word DEPTH-1 SHALL move the state to IDLE.
- busy SHALL therefore stay high for exactly DEPTH cycles after rst deasserts.
REQ-013 Write: in IDLE, load=1 at a rising edge SHALL store d_in into mem[address]; load=0 SHALL leave all words unchanged.
REQ-014 Read: d_out SHALL equal mem[address] combinationally. A write becomes visible on d_out from the cycle after its edge. This holds in the base build, without READ_BYPASS_EN.
REQ-015 While busy=1:
- load SHALL be ignored and no user write SHALL occur.
- d_out SHALL be 0.
REQ-016 Consecutive writes to the same address on successive edges SHALL each take effect. The last write wins.
REQ-017 Address is taken modulo DEPTH. No out-of-range condition exists.
REQ-018 Every word not written since the last clear SHALL read 0.

Reset
REQ-019 rst high at a rising edge SHALL force state=CLEAR and ptr=0, and SHALL leave mem unmodified on that edge.
REQ-020 Output values with rst high:
- busy SHALL be 1 and d_out SHALL be 0 from the cycle after the first rst edge.
- These values SHALL hold throughout the time rst is asserted.
REQ-021 rst asserted during a clear sequence SHALL restart the sequence from ptr=0.
REQ-022 rst asserted in IDLE with load=1 SHALL NOT perform the write.

Configuration
REQ-023 Macro RAM8_READ_BYPASS_EN, when defined:
- In IDLE with load=1, d_out SHALL equal d_in in the same cycle.
- In all other cases, behaviour follows REQ-014.
REQ-024 Without RAM8_READ_BYPASS_EN, d_out SHALL always show the stored value, as in REQ-014.
REQ-025 Busy masking per REQ-015 SHALL apply in both builds.

Structure
REQ-026 Shared package hack_pkg SHALL hold:
- WORD_W = 16;
- the state enum ram_state_t {IDLE, CLEAR}.
REQ-027 Sub-module word_reg SHALL implement one WIDTH-bit register: clk, load, d_in, d_out.
REQ-028 ram8_clear SHALL instantiate DEPTH word_reg copies plus a clear FSM and read mux. There SHALL be no other hierarchy.

Verification
REQ-029 Reset clear:
- Stimulus: pulse rst for 1 cycle, then hold load=0.
- Response: busy=1 for exactly 8 cycles, then 0; all 8 addresses then read 0x0000.
REQ-030 Basic write:
- Stimulus: in IDLE, write address=3, d_in=0xBEEF.
- Response: d_out(address 3)=0xBEEF on the next cycle; address 2 and address 4 still read 0x0000.
REQ-031 Write while busy:
- Stimulus: load=1, address=5, d_in=0x1234 during cycles 2–4 of a clear.
- Response: after the clear, address 5 reads 0x0000.
REQ-032 Reset mid-clear:
- Stimulus: assert rst at clear cycle 5.
- Response: busy stays high for 8 further cycles after rst drops; all words read 0.
REQ-033 Back-to-back writes:
- Stimulus: address=7, d_in=0x0001 on one edge, then 0xFFFF on the next.
- Response: address 7 reads 0xFFFF.
- With RAM8_READ_BYPASS_EN: d_out=0xFFFF in the write cycle itself.
REQ-034 Write then reset:
- Stimulus: write address=0, d_in=0xAAAA; then assert rst with load=1 and d_in=0x5555.
- Response: after the clear, address 0 reads 0x0000.
